// File: rtl/mano_mem_responder.sv
// Memory-side responder for the Mano-style CPU bus: word RAM with a
// combinational read path, a memory-mapped transmit byte FIFO and a one-entry
// receive holding register, plus a side-band preload port for program memory.
module mano_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_AW     = 12,
    parameter int unsigned TX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  we_n,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ld_en,
    input  logic [MEM_AW-1:0]     ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data_in,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    localparam int unsigned TX_PW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_PW + 1;

    localparam logic [ADDR_WIDTH-1:0] A_TXDATA = ADDR_WIDTH'('hFF0);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('hFF1);
    localparam logic [ADDR_WIDTH-1:0] A_RXDATA = ADDR_WIDTH'('hFF2);
    localparam logic [ADDR_WIDTH-1:0] A_RXACK  = ADDR_WIDTH'('hFF3);

    logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

    logic sel_txdata, sel_status, sel_rxdata, sel_rxack, sel_ram;

    logic we_n_q, we_n_d;
    logic io_wr_first;

    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [TX_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TX_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic             tx_ovf_q, tx_ovf_d;
    logic             tx_full, tx_empty, tx_pop, tx_push_req, tx_push, tx_ovf_set;

    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_accept, rx_ack;

    // Address decode: the I/O window overrides the RAM region it overlaps
    always_comb begin
        sel_txdata = (addr == A_TXDATA);
        sel_status = (addr == A_STATUS);
        sel_rxdata = (addr == A_RXDATA);
        sel_rxack  = (addr == A_RXACK);
        sel_ram    = (addr[ADDR_WIDTH-1:MEM_AW] == '0) &&
                     !(sel_txdata || sel_status || sel_rxdata || sel_rxack);
    end

    // Write-run edge detect so a multi-cycle write strobe fires I/O side effects once
    always_comb begin
        we_n_d      = we_n;
        io_wr_first = !we_n && we_n_q;
    end

    // Transmit FIFO next state; a pop in the same cycle frees a slot for a push into a full FIFO
    always_comb begin
        tx_full     = (tx_count_q == TX_CW'(TX_DEPTH));
        tx_empty    = (tx_count_q == '0);
        tx_pop      = !tx_empty && tx_ready;
        tx_push_req = io_wr_first && sel_txdata;
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        tx_ovf_set  = tx_push_req && tx_full && !tx_pop;

        tx_mem_d   = tx_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tx_count_d = tx_count_q;
        tx_ovf_d   = tx_ovf_q;

        if (tx_push) begin
            tx_mem_d[wr_ptr_q] = cpu_wdata[7:0];
            wr_ptr_d           = wr_ptr_q + TX_PW'(1);
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + TX_PW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
            2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
            default: tx_count_d = tx_count_q;
        endcase

        if (tx_ovf_set) begin
            tx_ovf_d = 1'b1;
        end else if (io_wr_first && sel_status) begin
            tx_ovf_d = 1'b0;
        end
    end

    // Receive holding register next state
    always_comb begin
        rx_accept = rx_valid && !rx_full_q;
        rx_ack    = io_wr_first && sel_rxack;
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        if (rx_accept) begin
            rx_full_d = 1'b1;
            rx_byte_d = rx_data_in;
        end else if (rx_ack) begin
            rx_full_d = 1'b0;
        end
    end

    // Stream outputs come straight from registered state
    always_comb begin
        tx_valid = !tx_empty;
        tx_data  = tx_mem_q[rd_ptr_q];
        rx_ready = !rx_full_q;
    end

    // Combinational CPU read mux
    always_comb begin
        cpu_rdata = '0;
        if (sel_status) begin
            cpu_rdata = DATA_WIDTH'({4'(tx_count_q), rx_full_q, tx_ovf_q, tx_empty, tx_full});
        end else if (sel_rxdata) begin
            cpu_rdata = DATA_WIDTH'(rx_byte_q);
        end else if (sel_ram) begin
            cpu_rdata = mem[addr[MEM_AW-1:0]];
        end
    end

    // RAM writes: preload has priority and drops a coincident CPU write; contents survive reset
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (!we_n && sel_ram) begin
            mem[addr[MEM_AW-1:0]] <= cpu_wdata;
        end
    end

    // Control, FIFO and receive state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_n_q     <= 1'b1;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            tx_count_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_full_q  <= 1'b0;
            rx_byte_q  <= '0;
            for (int unsigned i = 0; i < TX_DEPTH; i++) begin
                tx_mem_q[i] <= '0;
            end
        end else begin
            we_n_q     <= we_n_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            tx_count_q <= tx_count_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_full_q  <= rx_full_d;
            rx_byte_q  <= rx_byte_d;
            tx_mem_q   <= tx_mem_d;
        end
    end

endmodule

// File: tb/tb_mano_mem_responder.sv
// Bench for mano_mem_responder: queue-based reference model, read/stream
// scoreboards, directed scenarios followed by randomized bus traffic.
module tb_mano_mem_responder;

    localparam int unsigned DEPTH = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [15:0] addr       = '0;
    logic [15:0] cpu_wdata  = '0;
    logic        we_n       = 1'b1;
    logic [15:0] cpu_rdata;
    logic        ld_en      = 1'b0;
    logic [11:0] ld_addr    = '0;
    logic [15:0] ld_data    = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready   = 1'b0;
    logic [7:0]  rx_data_in = '0;
    logic        rx_valid   = 1'b0;
    logic        rx_ready;

    mano_mem_responder #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .MEM_AW    (12),
        .TX_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .cpu_wdata (cpu_wdata),
        .we_n      (we_n),
        .cpu_rdata (cpu_rdata),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data_in(rx_data_in),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] ram_m [4096];
    logic [7:0]  txq [$];
    logic        ovf_m    = 1'b0;
    logic        rxf_m    = 1'b0;
    logic [7:0]  rxb_m    = '0;
    logic        wq_m     = 1'b1;
    logic        pushed_m = 1'b0;

    // Scoreboards
    logic [7:0]  sb_tx [$];
    logic [15:0] rd_exp [$];
    string       rd_nm [$];
    logic        chk_rd = 1'b0;
    logic        mon_en = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic is_io(input logic [15:0] a);
        return (a >= 16'hFF0) && (a <= 16'hFF3);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a == 16'hFF1)
            return {8'h00, 4'(txq.size()), rxf_m, ovf_m, txq.size() == 0, txq.size() == DEPTH};
        if (a == 16'hFF2)
            return {8'h00, rxb_m};
        if (is_io(a) || a >= 16'h1000)
            return 16'h0000;
        return ram_m[a[11:0]];
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is a queue, a pop frees a slot before the push is judged
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            txq.delete();
            sb_tx.delete();
            ovf_m    <= 1'b0;
            rxf_m    <= 1'b0;
            rxb_m    <= '0;
            wq_m     <= 1'b1;
            pushed_m <= 1'b0;
        end else begin
            if (ld_en)
                ram_m[ld_addr] <= ld_data;
            else if (!we_n && addr < 16'h1000 && !is_io(addr))
                ram_m[addr[11:0]] <= cpu_wdata;

            if (txq.size() > 0 && tx_ready)
                void'(txq.pop_front());
            if (!we_n && wq_m && addr == 16'hFF0) begin
                if (txq.size() < DEPTH) begin
                    txq.push_back(cpu_wdata[7:0]);
                    sb_tx.push_back(cpu_wdata[7:0]);
                    pushed_m <= 1'b1;
                end else begin
                    ovf_m <= 1'b1;
                end
            end
            if (!we_n && wq_m && addr == 16'hFF1)
                ovf_m <= 1'b0;

            if (rx_valid && !rxf_m) begin
                rxb_m <= rx_data_in;
                rxf_m <= 1'b1;
            end else if (!we_n && wq_m && addr == 16'hFF3) begin
                rxf_m <= 1'b0;
            end
            wq_m <= we_n;
        end
    end

    // Monitor: compares DUT outputs mid-cycle against model and scoreboards
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_valid", 16'(tx_valid), 16'(txq.size() != 0));
            if (txq.size() != 0)
                chk("tx_head", 16'(tx_data), 16'(txq[0]));
            else if (!pushed_m)
                chk("tx_data_after_reset", 16'(tx_data), 16'h0000);
            chk("rx_ready", 16'(rx_ready), 16'(!rxf_m));
            if (tx_valid && tx_ready) begin
                if (sb_tx.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL tx_stream: got 0x%h, expected no transfer", tx_data);
                end else begin
                    chk("tx_stream", 16'(tx_data), 16'(sb_tx.pop_front()));
                end
            end
            if (chk_rd) begin
                if (rd_exp.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL read: got 0x%h, expected no read pending", cpu_rdata);
                end else begin
                    chk(rd_nm.pop_front(), cpu_rdata, rd_exp.pop_front());
                end
            end
        end
    end

    task automatic cyc_idle();
        @(posedge clk); #1;
        we_n = 1'b1; ld_en = 1'b0; chk_rd = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk); #1;
            addr = a; cpu_wdata = d; we_n = 1'b0; ld_en = 1'b0; chk_rd = 1'b0;
        end
    endtask

    task automatic ld(input logic [11:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d; we_n = 1'b1; chk_rd = 1'b0;
    endtask

    task automatic rdc(input logic [15:0] a, input logic [15:0] e, input string nm);
        @(posedge clk); #1;
        addr = a; we_n = 1'b1; ld_en = 1'b0; chk_rd = 1'b1;
        rd_exp.push_back(e);
        rd_nm.push_back(nm);
    endtask

    task automatic rdm(input logic [15:0] a, input string nm);
        @(posedge clk); #1;
        addr = a; we_n = 1'b1; ld_en = 1'b0; chk_rd = 1'b1;
        rd_exp.push_back(m_read(a));
        rd_nm.push_back(nm);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 16'($urandom_range(0, 4095));
            3:       return 16'hFF0 + 16'($urandom_range(0, 3));
            4:       return 16'h1000 + 16'($urandom_range(0, 16'hEFFF));
            default: return 16'hFFFF;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Fill program memory, then the known word
        for (int unsigned i = 0; i < 4096; i++)
            ld(12'(i), 16'($urandom));
        ld(12'h010, 16'h1234);

        // RAM read, out-of-range read, CPU write, CPU write dropped by preload
        rdc(16'h0010, 16'h1234, "ram_preload");
        rdc(16'h2000, 16'h0000, "out_of_range");
        wr(16'h0020, 16'hBEEF, 1);
        rdc(16'h0020, 16'hBEEF, "ram_cpu_write");
        @(posedge clk); #1;
        addr = 16'h0020; cpu_wdata = 16'h1111; we_n = 1'b0;
        ld_en = 1'b1; ld_addr = 12'h030; ld_data = 16'hCAFE; chk_rd = 1'b0;
        rdc(16'h0020, 16'hBEEF, "ram_write_dropped");
        rdc(16'h0030, 16'hCAFE, "ram_ld_wins");

        // Two-cycle write strobe pushes once; one pop empties
        tx_ready = 1'b0;
        wr(16'hFF0, 16'h0041, 2);
        rdc(16'hFF1, 16'h0010, "status_one_entry");
        tx_ready = 1'b1;
        cyc_idle();
        tx_ready = 1'b0;
        rdc(16'hFF1, 16'h0002, "status_empty");

        // Overflow, clear, drain in order
        for (int k = 1; k <= 5; k++) begin
            wr(16'hFF0, 16'(k), 1);
            cyc_idle();
        end
        rdc(16'hFF1, 16'h0045, "status_full_ovf");
        wr(16'hFF1, 16'h0000, 1);
        rdc(16'hFF1, 16'h0041, "status_ovf_cleared");
        tx_ready = 1'b1;
        repeat (6) cyc_idle();
        tx_ready = 1'b0;
        rdc(16'hFF1, 16'h0002, "status_drained");

        // Receive register hold-off and acknowledge
        rx_data_in = 8'h5A; rx_valid = 1'b1;
        cyc_idle();
        rx_data_in = 8'h77;
        rdc(16'hFF2, 16'h005A, "rxdata_first");
        repeat (2) cyc_idle();
        rdc(16'hFF2, 16'h005A, "rxdata_held");
        wr(16'hFF3, 16'h0000, 1);
        rdc(16'hFF2, 16'h005A, "rxdata_after_ack");
        rdc(16'hFF2, 16'h0077, "rxdata_second");
        rx_valid = 1'b0;
        wr(16'hFF3, 16'h0000, 1);
        cyc_idle();

        // Reset mid-drain, then a write run spanning reset release
        for (int k = 0; k < 3; k++) begin
            wr(16'hFF0, 16'h00A1 + 16'(k), 1);
            cyc_idle();
        end
        tx_ready = 1'b1;
        cyc_idle();
        reset = 1'b1; tx_ready = 1'b0;
        rdc(16'hFF1, 16'h0002, "status_in_reset");
        wr(16'hFF0, 16'h0099, 1);
        reset = 1'b0;
        wr(16'hFF0, 16'h0099, 1);
        rdc(16'hFF1, 16'h0010, "status_run_after_reset");
        rdc(16'h0010, 16'h1234, "ram_kept_0010");
        rdc(16'h0020, 16'hBEEF, "ram_kept_0020");
        rdc(16'h0030, 16'hCAFE, "ram_kept_0030");
        tx_ready = 1'b1;
        repeat (2) cyc_idle();

        // Randomized traffic checked against the model
        for (int it = 0; it < 800; it++) begin
            tx_ready   = ($urandom_range(0, 2) != 0);
            rx_valid   = ($urandom_range(0, 3) == 0);
            rx_data_in = 8'($urandom);
            case ($urandom_range(0, 6))
                0:       wr(16'($urandom_range(0, 4095)), 16'($urandom), $urandom_range(1, 2));
                1:       ld(12'($urandom), 16'($urandom));
                2, 3:    rdm(pick_addr(), "rand_read");
                4:       wr(16'hFF0 + 16'($urandom_range(0, 3)), 16'($urandom), $urandom_range(1, 3));
                5:       rdm(16'hFF1, "rand_status");
                default: cyc_idle();
            endcase
        end

        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (10) cyc_idle();
        chk("tx_all_delivered", 16'(sb_tx.size()), 16'h0000);
        chk("reads_all_checked", 16'(rd_exp.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
